sseg_scan_controller: RTL and testbench
=======================================

// Module: sseg_scan_controller
// PURPOSE
//  Time-multiplexes one shared BCD-to-7-segment decoder across N common-anode digits.
//  Sits between the occupancy counter's BCD digits and the board display pins.
//  Snapshots digits once per frame so a display never tears mid-scan.
//  Adds anode dead-time against ghosting, leading-zero blanking and a frame-done pulse.
// PARAMETERS
//  N_DIGITS      4        number of digits scanned (>=2)
//  REFRESH_DIV   100000   clk cycles per digit slot (> BLANK_CYCLES)
//  BLANK_CYCLES  16       cycles at slot start with all anodes off (0 = no dead-time)
//  LZ_BLANK      1        1 = blank leading zeros; 0 = show every digit
// PORTS
//  clk_i         in   1            system clock
//  rst_ni        in   1            asynchronous reset, active-low
//  enable_i      in   1            1 = scanning; 0 = display dark
//  digits_i      in   4*N_DIGITS   BCD digits, [3:0] = digit 0 (least significant, rightmost)
//  dp_i          in   N_DIGITS     decimal point per digit, 1 = lit
//  anode_o       out  N_DIGITS     digit select, active-low, at most one bit low
//  sseg_o        out  7            segments {g..a}, active-low
//  dp_o          out  1            decimal point, active-low
//  frame_done_o  out  1            1-cycle pulse on last cycle of digit N_DIGITS-1 slot
// BEHAVIOUR
//  - Reset (async assert, sync release): anode_o all 1, sseg_o 7'h7F, dp_o 1, frame_done_o 0,
//    FSM IDLE, slot counter 0, digit index 0, shadow register 0.
//  - FSM states:
//    IDLE: entered at reset or when enable_i=0; outputs dark.
//    BLANK: first BLANK_CYCLES cycles of a slot.
//    SHOW: remaining cycles of the slot.
//  - Transitions:
//    IDLE->BLANK when enable_i=1; shadow <- digits_i/dp_i on that cycle; index 0.
//    BLANK->SHOW when slot count = BLANK_CYCLES-1. With BLANK_CYCLES=0, skip BLANK entirely.
//    SHOW->BLANK (or SHOW if no dead-time) when slot count = REFRESH_DIV-1; index advances.
//    Index N_DIGITS-1 wraps to 0; shadow reloads from inputs on the wrap cycle only.
//    Any state->IDLE on the cycle after enable_i=0; counter and index clear.
//  - Slot counter: 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV); resets to 0 each slot.
//  - All outputs registered: 1-cycle latency from state/index to pins.
//  - In SHOW:
//    anode_o = ~(1<<index).
//    sseg_o = decode(shadow digit), or 7'h7F when blanked.
//    dp_o = ~shadow dp[index].
//  - In BLANK/IDLE: anode_o all 1, sseg_o 7'h7F, dp_o 1.
//  - Blanking:
//    Digit i>0 blanked when LZ_BLANK=1 and shadow digits i..N_DIGITS-1 are all 0.
//    Digit 0 is never blanked by leading-zero rule.
//    Any BCD value >9 is always blanked; the decoder is only ever fed 0-9.
//    dp is still driven on a blanked digit; anode stays active if dp lit, else anode off.
//  - frame_done_o asserts on the cycle the index wraps; never asserted in IDLE.
//  - digits_i changes mid-frame are invisible until the next wrap.
// STRUCTURE
//  - Package sseg_pkg: state enum {IDLE,BLANK,SHOW}; SSEG_BLANK = 7'h7F; BCD_W = 4.
//  - Sub-module: one hex_to_7_segment instance on the muxed shadow digit.
//  - Remainder: FSM, slot counter, index counter, shadow register, blank logic, output regs.
// TESTING (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1)
//  - Reset: drop rst_ni mid-SHOW -> same cycle anode_o=4'hF, sseg_o=7'h7F, dp_o=1.
//  - Scan timing: enable, digits=16'h1234 -> per slot, 2 cycles dark then 6 cycles lit.
//    Digit order 4,3,2,1 with anodes E,D,B,7.
//    Digit 4 slot shows sseg=7'b0011001.
//    frame_done pulses every 32 cycles.
//  - Leading zeros: digits=16'h0070 -> digits 3 and 2 dark, anode never D or... never 7/B.
//    Digit 1 shows 7'b1111000; digit 0 shows 7'b1000000.
//    digits=0 -> only digit 0 lit, showing "0".
//  - Tearing: change digits 16'h1234->16'h5678 during digit 1 slot -> rest of frame shows 1,2.
//    5678 appears from next frame start.
//  - Invalid/dp: digits=16'h00A5, dp=4'b0100 -> digit 1 (A) blank.
//    Digit 2 anode active with sseg=7'h7F, dp_o=0; digit 3 dark.
//  - Disable: enable_i=0 mid-SHOW -> next cycle dark, no frame_done.
//    Re-enable -> starts at digit 0 BLANK with a fresh snapshot.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package sseg_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/hex_to_7_segment.sv
// Combinational hex to seven-segment decoder, segments {g..a}, active-low.
module hex_to_7_segment
    import sseg_pkg::*;
(
    input  logic [BCD_W-1:0] value,
    output logic [6:0]       seg
);

    always_comb begin
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/sseg_scan_controller.sv
// Scans N common-anode digits through one shared decoder, with per-frame digit snapshot,
// anode dead-time, leading-zero blanking and a frame-done pulse. rst_ni release is assumed synchronous.
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [BCD_W*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]       dp_i,
    output logic [N_DIGITS-1:0]       anode_o,
    output logic [6:0]                sseg_o,
    output logic                      dp_o,
    output logic                      frame_done_o
);

    localparam int                CNT_W      = $clog2(REFRESH_DIV);
    localparam int                IDX_W      = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam state_e            SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_e                    state;
    logic [CNT_W-1:0]          slot_cnt;
    logic [IDX_W-1:0]          idx;
    logic [BCD_W*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]       shadow_dp;

    logic slot_end;
    logic frame_end;

    assign slot_end  = (state == SHOW) && (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            slot_cnt      <= '0;
            idx           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
        end else if (!enable_i) begin
            state    <= IDLE;
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= SLOT_START;
                    slot_cnt      <= '0;
                    idx           <= '0;
                    shadow_digits <= digits_i;
                    shadow_dp     <= dp_i;
                end
                BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state <= SHOW;
                    end
                    slot_cnt <= slot_cnt + 1'b1;
                end
                SHOW: begin
                    if (slot_end) begin
                        state    <= SLOT_START;
                        slot_cnt <= '0;
                        if (frame_end) begin
                            // Snapshot only on the wrap so a frame never mixes old and new digits.
                            idx           <= '0;
                            shadow_digits <= digits_i;
                            shadow_dp     <= dp_i;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [N_DIGITS-1:0] zero_from;
    logic                zero_run;
    logic [BCD_W-1:0]    cur_digit;
    logic [BCD_W-1:0]    dec_in;
    logic                cur_dp;
    logic                invalid;
    logic                lz_blank;
    logic                blank;
    logic [6:0]          seg_dec;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        // zero_from[i] is set when digits i..N_DIGITS-1 are all zero.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow_digits[BCD_W*i +: BCD_W] == '0);
            zero_from[i] = zero_run;
        end
    end

    assign cur_digit = shadow_digits[BCD_W*idx +: BCD_W];
    assign cur_dp    = shadow_dp[idx];
    assign invalid   = (cur_digit > 4'd9);
    assign lz_blank  = LZ_BLANK && (idx != '0) && zero_from[idx];
    assign blank     = invalid || lz_blank;
    assign dec_in    = invalid ? '0 : cur_digit;

    hex_to_7_segment u_decoder (
        .value (dec_in),
        .seg   (seg_dec)
    );

    logic [N_DIGITS-1:0] onehot;
    logic [N_DIGITS-1:0] anode_next;
    logic [6:0]          sseg_next;
    logic                dp_next;
    logic                frame_done_next;

    // Gating with enable_i makes the pins go dark on the cycle after enable drops.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        anode_next  = '1;
        sseg_next   = SSEG_BLANK;
        dp_next     = 1'b1;
        if (enable_i && (state == SHOW)) begin
            dp_next = ~cur_dp;
            if (!blank) begin
                anode_next = ~onehot;
                sseg_next  = seg_dec;
            end else if (cur_dp) begin
                anode_next = ~onehot;
            end
        end
    end

    assign frame_done_next = enable_i && frame_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            anode_o      <= '1;
            sseg_o       <= SSEG_BLANK;
            dp_o         <= 1'b1;
            frame_done_o <= 1'b0;
        end else begin
            anode_o      <= anode_next;
            sseg_o       <= sseg_next;
            dp_o         <= dp_next;
            frame_done_o <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with 4 digits, 8-cycle slots and 2 dead-time cycles.
module tb_sseg_scan_controller;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] DARK  = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  anode;
    logic [6:0]  sseg;
    logic        dp_pin;
    logic        frame_done;

    int pass_count  = 0;
    int fail_count  = 0;
    int total_count = 0;

    sseg_scan_controller #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .digits_i     (digits),
        .dp_i         (dp),
        .anode_o      (anode),
        .sseg_o       (sseg),
        .dp_o         (dp_pin),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpv, input logic fd);
        check({tag, " anode"}, 32'(anode), 32'(an));
        check({tag, " sseg"},  32'(sseg),  32'(seg));
        check({tag, " dp"},    32'(dp_pin), 32'(dpv));
        check({tag, " frame"}, 32'(frame_done), 32'(fd));
    endtask

    // One digit slot as seen on the pins: two dark cycles, then six lit cycles.
    task automatic check_slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpv, input logic last);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 2) check_pins($sformatf("%s c%0d", tag, i), 4'hF, DARK, 1'b1, 1'b0);
            else       check_pins($sformatf("%s c%0d", tag, i), an, seg, dpv, last && (i == 7));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        digits = 16'h0000;
        dp     = 4'b0000;

        // Reset state and idle with enable low.
        @(negedge clk);
        check_pins("reset", 4'hF, DARK, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_pins("idle", 4'hF, DARK, 1'b1, 1'b0);
        end

        // Scan timing and digit order with 1234, two full frames.
        digits = 16'h1234;
        enable = 1'b1;
        @(negedge clk);
        check_pins("start", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f1 d0", 4'hE, SEG_4, 1'b1, 1'b0);
        check_slot("f1 d1", 4'hD, SEG_3, 1'b1, 1'b0);
        check_slot("f1 d2", 4'hB, SEG_2, 1'b1, 1'b0);
        check_slot("f1 d3", 4'h7, SEG_1, 1'b1, 1'b1);

        // Mid-frame change stays invisible until the next wrap.
        check_slot("f2 d0", 4'hE, SEG_4, 1'b1, 1'b0);
        digits = 16'h5678;
        check_slot("f2 d1", 4'hD, SEG_3, 1'b1, 1'b0);
        check_slot("f2 d2", 4'hB, SEG_2, 1'b1, 1'b0);
        check_slot("f2 d3", 4'h7, SEG_1, 1'b1, 1'b1);

        check_slot("f3 d0", 4'hE, SEG_8, 1'b1, 1'b0);
        digits = 16'h0070;
        check_slot("f3 d1", 4'hD, SEG_7, 1'b1, 1'b0);
        check_slot("f3 d2", 4'hB, SEG_6, 1'b1, 1'b0);
        check_slot("f3 d3", 4'h7, SEG_5, 1'b1, 1'b1);

        // Leading zeros: 0070.
        check_slot("f4 d0", 4'hE, SEG_0, 1'b1, 1'b0);
        digits = 16'h0000;
        check_slot("f4 d1", 4'hD, SEG_7, 1'b1, 1'b0);
        check_slot("f4 d2", 4'hF, DARK,  1'b1, 1'b0);
        check_slot("f4 d3", 4'hF, DARK,  1'b1, 1'b1);

        // All zero: only digit 0 lit.
        check_slot("f5 d0", 4'hE, SEG_0, 1'b1, 1'b0);
        digits = 16'h00A5;
        dp     = 4'b0100;
        check_slot("f5 d1", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f5 d2", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f5 d3", 4'hF, DARK, 1'b1, 1'b1);

        // Invalid BCD blanked; blanked digit with lit dp keeps its anode.
        check_slot("f6 d0", 4'hE, SEG_5, 1'b1, 1'b0);
        digits = 16'h1234;
        dp     = 4'b0000;
        check_slot("f6 d1", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f6 d2", 4'hB, DARK, 1'b0, 1'b0);
        check_slot("f6 d3", 4'hF, DARK, 1'b1, 1'b1);

        // Disable mid-SHOW of digit 1.
        check_slot("f7 d0", 4'hE, SEG_4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 2) check_pins($sformatf("f7 d1 c%0d", i), 4'hF, DARK, 1'b1, 1'b0);
            else       check_pins($sformatf("f7 d1 c%0d", i), 4'hD, SEG_3, 1'b1, 1'b0);
        end
        enable = 1'b0;
        digits = 16'h9876;
        dp     = 4'b0001;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_pins($sformatf("off c%0d", i), 4'hF, DARK, 1'b1, 1'b0);
        end

        // Re-enable: fresh snapshot, starting at digit 0.
        enable = 1'b1;
        @(negedge clk);
        check_pins("restart", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f8 d0", 4'hE, SEG_6, 1'b0, 1'b0);
        check_slot("f8 d1", 4'hD, SEG_7, 1'b1, 1'b0);
        check_slot("f8 d2", 4'hB, SEG_8, 1'b1, 1'b0);
        check_slot("f8 d3", 4'h7, SEG_9, 1'b1, 1'b1);

        // Asynchronous reset while digit 0 is lit.
        repeat (2) begin
            @(negedge clk);
            check_pins("pre-rst dark", 4'hF, DARK, 1'b1, 1'b0);
        end
        @(negedge clk);
        check_pins("pre-rst lit", 4'hE, SEG_6, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_pins("async rst", 4'hF, DARK, 1'b1, 1'b0);
        @(negedge clk);
        check_pins("in rst", 4'hF, DARK, 1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_pins("post-rst", 4'hF, DARK, 1'b1, 1'b0);
        check_slot("f9 d0", 4'hE, SEG_6, 1'b0, 1'b0);
        check_slot("f9 d1", 4'hD, SEG_7, 1'b1, 1'b0);
        check_slot("f9 d2", 4'hB, SEG_8, 1'b1, 1'b0);
        check_slot("f9 d3", 4'h7, SEG_9, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
